// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC control unit.
//   ctrl_state_t : controller FSM states
//   C_*          : bit positions inside the core control word c[8:1]
package cordic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ITER,
        WR_X,
        WR_Y,
        DONE
    } ctrl_state_t;

    localparam int C_LOAD   = 1;  // load-mux select (take data_w)
    localparam int C_REG_EN = 2;  // working-register enable
    localparam int C_SEL_R  = 5;  // scaler source: 0 = x, 1 = y
    localparam int C_WR_X   = 6;  // reg_x enable
    localparam int C_WR_Y   = 7;  // reg_y enable
    localparam int C_ANG_EN = 8;  // angle-register enable

endpackage

// File: rtl/cordic_ctrl_if.sv
// Handshake and core-control bundle for cordic_ctrl.
//   start_valid / start_ready : upstream operand handshake (data on data_w)
//   res_valid   / res_ready   : downstream result handshake (data on data_r)
//   busy                      : operation in flight (ITER, WR_X, WR_Y)
//   c[8:1], cnt               : control word and iteration index for cordic_core
// Modport master is the controller side; slave is the environment around it.
interface cordic_ctrl_if #(
    parameter int CNT_W = 3
);
    logic             start_valid;
    logic             start_ready;
    logic             res_valid;
    logic             res_ready;
    logic             busy;
    logic [8:1]       c;
    logic [CNT_W-1:0] cnt;

    modport master (
        input  start_valid,
        input  res_ready,
        output start_ready,
        output res_valid,
        output busy,
        output c,
        output cnt
    );

    modport slave (
        output start_valid,
        output res_ready,
        input  start_ready,
        input  res_valid,
        input  busy,
        input  c,
        input  cnt
    );
endinterface

// File: rtl/cordic_ctrl.sv
// Control unit for the iterative CORDIC datapath (cordic_core).
// One operation: operand load (in the accepting IDLE cycle), N-1 in-place
// micro-rotations, then scaled write-back of x and then y, then the result
// is held until downstream takes it.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-low
//   ctl  : cordic_ctrl_if.master (start/result handshakes, busy, c, cnt)
// Parameters:
//   N     : number of micro-rotations, >= 2
//   CNT_W : width of cnt, matches the core's cnt port
module cordic_ctrl
    import cordic_pkg::*;
#(
    parameter int N     = 7,
    parameter int CNT_W = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    cordic_ctrl_if.master ctl
);

    if (N < 2) begin : g_bad_n
        $error("cordic_ctrl: N must be >= 2");
    end

    // Index held during both write-backs; the last ITER cycle runs at N-2.
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ITER_LAST = CNT_W'(N - 2);

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (ctl.start_valid) begin
                    state_nxt = ITER;
                end
            end
            ITER: begin
                if (cnt_q == CNT_ITER_LAST) begin
                    cnt_nxt   = CNT_LAST;
                    state_nxt = WR_X;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            WR_X: begin
                state_nxt = WR_Y;
            end
            WR_Y: begin
                state_nxt = DONE;
            end
            DONE: begin
                // start_valid is deliberately not looked at here: a new
                // operand can only be taken from IDLE, one cycle later.
                if (ctl.res_ready) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode
    always_comb begin
        ctl.c           = '0;
        ctl.start_ready = 1'b0;
        ctl.res_valid   = 1'b0;
        ctl.busy        = 1'b0;
        unique case (state)
            IDLE: begin
                ctl.start_ready = 1'b1;
                // Mealy load: the core latches data_w in the handshake cycle
                // itself, so ITER can start rotating on the very next edge.
                if (ctl.start_valid) begin
                    ctl.c[C_LOAD]   = 1'b1;
                    ctl.c[C_REG_EN] = 1'b1;
                    ctl.c[C_ANG_EN] = 1'b1;
                end
            end
            ITER: begin
                ctl.busy        = 1'b1;
                ctl.c[C_REG_EN] = 1'b1;
            end
            WR_X: begin
                // Working registers frozen while the scaler output is stored.
                ctl.busy      = 1'b1;
                ctl.c[C_WR_X] = 1'b1;
            end
            WR_Y: begin
                ctl.busy         = 1'b1;
                ctl.c[C_WR_Y]    = 1'b1;
                ctl.c[C_SEL_R]   = 1'b1;
            end
            DONE: begin
                ctl.res_valid = 1'b1;
            end
            default: begin
                ctl.c = '0;
            end
        endcase
    end

    assign ctl.cnt = cnt_q;

endmodule
